// File: rtl/xpb_pkg.sv
// xpb_pkg: shared defaults and FSM state encoding for the
// run-time xpb table writer.
package xpb_pkg;

   localparam int DATA_W_DEF = 1024;
   localparam int IDX_W_DEF  = 5;

   typedef enum logic [2:0] {
      IDLE,
      WR0,
      ADD,
      RED,
      FIN
   } state_t;

endpackage

// File: rtl/xpb_cond_sub.sv
// xpb_cond_sub: conditional subtract of N from a (DATA_W+1)-bit sum.
// Ports: sum_i (acc+B), mod_i (N), res_o (sum mod N, given sum < 2N).
module xpb_cond_sub #(
   parameter int DATA_W = 1024
) (
   input  logic [DATA_W:0]   sum_i,
   input  logic [DATA_W-1:0] mod_i,
   output logic [DATA_W-1:0] res_o
);

   logic              borrow;
   logic [DATA_W-1:0] diff;

   // Borrow of the full-width sum - N; the kept difference bits are
   // exactly the low DATA_W bits of that wide subtraction.
   assign borrow = sum_i < {1'b0, mod_i};
   assign diff   = sum_i[DATA_W-1:0] - mod_i;
   assign res_o  = borrow ? sum_i[DATA_W-1:0] : diff;

endmodule

// File: rtl/xpb_table_writer.sv
// xpb_table_writer: writes j*B mod N for j = 0..2^IDX_W-1 to a table.
// Ports: clk, rst_n, start/modulus/base in; busy, done, wr_en/addr/data out.
module xpb_table_writer
   import xpb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] modulus,
   input  logic [DATA_W-1:0] base,
   output logic              busy,
   output logic              done,
   output logic              wr_en,
   output logic [IDX_W-1:0]  wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] n_q, n_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W:0]   sum_q, sum_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              we_q, we_d;
   logic [IDX_W-1:0]  wa_q, wa_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic [DATA_W-1:0] red;

   xpb_cond_sub #(
      .DATA_W (DATA_W)
   ) u_sub (
      .sum_i (sum_q),
      .mod_i (n_q),
      .res_o (red)
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      we_d    = 1'b0;
      wa_d    = wa_q;
      wd_d    = wd_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               n_d     = modulus;
               b_d     = base;
               acc_d   = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = WR0;
            end
         end
         WR0: begin
            we_d    = 1'b1;
            wa_d    = '0;
            wd_d    = '0;
            state_d = ADD;
         end
         ADD: begin
            sum_d   = {1'b0, acc_q} + {1'b0, b_q};
            idx_d   = idx_q + 1'b1;
            state_d = RED;
         end
         RED: begin
            acc_d   = red;
            we_d    = 1'b1;
            wa_d    = idx_q;
            wd_d    = red;
            state_d = (&idx_q) ? FIN : ADD;
         end
         FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         we_q    <= we_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign wr_en   = we_q;
   assign wr_addr = wa_q;
   assign wr_data = wd_q;

endmodule
